serial_add_ctrl: RTL and testbench

//  Bit-serial add sequencer: accepts two W-bit operands over a valid/ready handshake.

---
 rtl/serial_add_pkg.sv | 16 +
 rtl/serial_add_ctrl_fa.sv | 17 +
 rtl/serial_add_ctrl.sv | 125 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial add sequencer.
//   sa_state_t : sequencer FSM encoding (IDLE, RUN, DONE)
//   cnt_width  : bit counter width, wide enough to hold W without wrapping
package serial_add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sa_state_t;

   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// One-bit full-adder cell shared by the serial add sequencer.
//   A, B : operand bits
//   Cin  : carry in
//   Sum  : A ^ B ^ Cin
//   Cout : majority(A, B, Cin)
module serial_add_ctrl_fa (
   input  logic A,
   input  logic B,
   input  logic Cin,
   output logic Sum,
   output logic Cout
);

   assign Sum  = A ^ B ^ Cin;
   assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add sequencer: accepts two W-bit operands, runs them LSB-first
// through one shared full-adder cell over W cycles, returns sum and carry-out.
// Optional macro SERIAL_ADD_SUB_EN adds a `sub` input selecting op_a - op_b.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (ready only in IDLE, not in reset)
//   op_a, op_b, cin      : operands and carry-in, sampled on accept
//   sub                  : (SERIAL_ADD_SUB_EN only) 1 = subtract, cin ignored
//   out_valid / out_ready: result handshake (valid only in DONE)
//   sum, cout            : result, stable while out_valid
//   busy                 : high in RUN or DONE
module serial_add_ctrl #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   input  logic         cin,
`ifdef SERIAL_ADD_SUB_EN
   input  logic         sub,
`endif
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         busy
);

   import serial_add_pkg::*;

   localparam int CNT_W = cnt_width(W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

   sa_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [W-1:0]     a_sh_q, a_sh_d;
   logic [W-1:0]     b_sh_q, b_sh_d;
   logic [W-1:0]     s_sh_q, s_sh_d;
   logic             fa_sum, fa_cout;

   serial_add_ctrl_fa u_fa (
      .A    (a_sh_q[0]),
      .B    (b_sh_q[0]),
      .Cin  (carry_q),
      .Sum  (fa_sum),
      .Cout (fa_cout)
   );

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == RUN) || (state_q == DONE);
   assign sum       = out_valid ? s_sh_q : '0;
   assign cout      = out_valid & carry_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      s_sh_d  = s_sh_q;

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               a_sh_d = op_a;
`ifdef SERIAL_ADD_SUB_EN
               // Subtraction as a + ~b + 1: invert B once at load time.
               b_sh_d  = sub ? ~op_b : op_b;
               carry_d = sub ? 1'b1 : cin;
`else
               b_sh_d  = op_b;
               carry_d = cin;
`endif
               s_sh_d  = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end

         RUN: begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            // Shift-then-insert keeps this valid for W == 1.
            s_sh_d        = s_sh_q >> 1;
            s_sh_d[W-1]   = fa_sum;
            carry_d       = fa_cout;
            cnt_d         = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
               state_d = DONE;
            end
         end

         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         s_sh_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         s_sh_q  <= s_sh_d;
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with W=8: table of operand vectors with
// hand-computed results, plus sequences for back-pressure, in_valid during
// RUN, reset mid-RUN and (with SERIAL_ADD_SUB_EN) subtraction.
module tb_serial_add_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] op_a, op_b;
   logic         cin;
`ifdef SERIAL_ADD_SUB_EN
   logic         sub;
`endif
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         busy;

   int checks = 0;
   int errors = 0;

   serial_add_ctrl #(.W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         c;
      logic         s;
      logic [W-1:0] exp_sum;
      logic         exp_cout;
      int           hold;
      bit           keep_valid;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Entered at #1 after a rising edge with the DUT in IDLE.
   task automatic run_op(input vec_t v, input string name);
      int lat;
      op_a      = v.a;
      op_b      = v.b;
      cin       = v.c;
`ifdef SERIAL_ADD_SUB_EN
      sub       = v.s;
`endif
      in_valid  = 1'b1;
      out_ready = (v.hold == 0);
      check({name, " in_ready"}, 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      if (v.keep_valid) begin
         // Changed operands during RUN must be ignored.
         op_a = ~v.a;
         op_b = ~v.b;
         cin  = ~v.c;
      end else begin
         in_valid = 1'b0;
      end
      lat = 1;
      while (!out_valid && lat < 4 * W + 8) begin
         if (v.keep_valid) check({name, " in_ready_run"}, 64'(in_ready), 64'd0);
         @(posedge clk); #1;
         lat++;
      end
      in_valid = 1'b0;
      check({name, " latency"}, 64'(lat), 64'(W + 1));
      check({name, " sum"}, 64'(sum), 64'(v.exp_sum));
      check({name, " cout"}, 64'(cout), 64'(v.exp_cout));
      check({name, " busy"}, 64'(busy), 64'd1);
      for (int i = 0; i < v.hold; i++) begin
         @(posedge clk); #1;
         check({name, " hold_valid"}, 64'(out_valid), 64'd1);
         check({name, " hold_sum"}, 64'(sum), 64'(v.exp_sum));
         check({name, " hold_cout"}, 64'(cout), 64'(v.exp_cout));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check({name, " idle_valid"}, 64'(out_valid), 64'd0);
      check({name, " idle_ready"}, 64'(in_ready), 64'd1);
      check({name, " idle_busy"}, 64'(busy), 64'd0);
      out_ready = 1'b0;
   endtask

   initial begin
      vec_t v;

      vecs.push_back('{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 0, 1'b0});
      vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0});
      vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 0, 1'b1});
      vecs.push_back('{8'h55, 8'hAA, 1'b0, 1'b0, 8'hFF, 1'b0, 5, 1'b0});
      vecs.push_back('{8'h55, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b0});
      vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 2, 1'b0});
      vecs.push_back('{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 0, 1'b0});
      vecs.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0});

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      op_a      = '0;
      op_b      = '0;
      cin       = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub       = 1'b0;
`endif
      #1;
      check("rst in_ready_now", 64'(in_ready), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      check("rst in_ready", 64'(in_ready), 64'd0);
      check("rst out_valid", 64'(out_valid), 64'd0);
      check("rst sum", 64'(sum), 64'd0);
      check("rst cout", 64'(cout), 64'd0);
      check("rst busy", 64'(busy), 64'd0);
      rst = 1'b0;
      #1;
      check("post_rst in_ready", 64'(in_ready), 64'd1);

      foreach (vecs[i]) begin
         run_op(vecs[i], $sformatf("vec%0d", i));
      end

      // Reset asserted during the 4th RUN cycle discards the partial result.
      op_a     = 8'h12;
      op_b     = 8'h34;
      cin      = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("midrun busy", 64'(busy), 64'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrun_rst in_ready", 64'(in_ready), 64'd0);
      rst = 1'b0;
      #1;
      check("midrun_rst out_valid", 64'(out_valid), 64'd0);
      check("midrun_rst sum", 64'(sum), 64'd0);
      check("midrun_rst cout", 64'(cout), 64'd0);
      check("midrun_rst busy", 64'(busy), 64'd0);
      check("midrun_rst in_ready_after", 64'(in_ready), 64'd1);
      v = '{8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 0, 1'b0};
      run_op(v, "after_rst");

`ifdef SERIAL_ADD_SUB_EN
      v = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 0, 1'b0};
      run_op(v, "sub_5m7");
      v = '{8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1, 0, 1'b0};
      run_op(v, "sub_7m5");
      v = '{8'h0F, 8'h01, 1'b1, 1'b0, 8'h11, 1'b0, 0, 1'b0};
      run_op(v, "sub0_add");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
